// File: rtl/fir_ctrl.sv
// fir_ctrl: coefficient shadow bank with atomic commit to the active bus b,
// delay-line flush after every commit, and the sample-rate strobe in run mode.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | halted; writes accepted; waits for run or commit
// S_RUN   | streaming; divider produces fir_ena every DIV cycles
// S_SWAP  | one cycle; shadow bank copied onto b
// S_FLUSH | DELAYS+1 cycles with fir_rst high, then commit_done pulse
module fir_ctrl #(
  parameter int DELAYS = 3,
  parameter int N      = 32,
  parameter int DIV    = 4,
  localparam int IW    = ($clog2(DELAYS + 1) > 1) ? $clog2(DELAYS + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              coef_data,
  input  logic [IW-1:0]             coef_idx,
  input  logic                      coef_valid,
  output logic                      coef_ready,
  output logic                      coef_err,
  input  logic                      commit,
  output logic                      commit_done,
  input  logic                      run,
  output logic [(DELAYS+1)*N-1:0]   b,
  output logic                      fir_ena,
  output logic                      fir_rst,
  output logic                      busy
);

  localparam int CW = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
  localparam int FW = ($clog2(DELAYS + 1) > 1) ? $clog2(DELAYS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWAP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                   r_state;
  logic [N-1:0]             r_shadow [DELAYS+1];
  logic [(DELAYS+1)*N-1:0]  r_b;
  logic [CW-1:0]            r_cnt;
  logic [FW-1:0]            r_fcnt;
  logic                     r_err;
  logic                     r_done;
  logic                     r_ena;
  logic                     r_frst;

  logic                     w_idle_run;
  logic                     w_accept;
  logic                     w_idx_bad;

  assign w_idle_run  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign coef_ready  = !rst && w_idle_run;
  assign busy        = (r_state == S_SWAP) || (r_state == S_FLUSH);
  assign w_accept    = coef_valid && coef_ready;
  assign w_idx_bad   = coef_idx > IW'(DELAYS);

  assign coef_err    = r_err;
  assign commit_done = r_done;
  assign fir_ena     = r_ena;
  assign fir_rst     = r_frst;
  assign b           = r_b;

  // Shadow bank and sticky index error; out-of-range writes complete but store nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DELAYS; i++) r_shadow[i] <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      if (w_idx_bad) r_err <= 1'b1;
      for (int i = 0; i <= DELAYS; i++) begin
        if (coef_idx == IW'(i)) r_shadow[i] <= coef_data;
      end
    end
  end

  // Sequencer: run/halt, sample divider, commit swap and delay-line flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_done  <= 1'b0;
      r_ena   <= 1'b0;
      r_frst  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ena  <= 1'b0;
      r_frst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (commit)   r_state <= S_SWAP;
          else if (run) r_state <= S_RUN;
        end
        S_RUN: begin
          // Leaving RUN suppresses a strobe that would otherwise land outside RUN.
          if (commit) begin
            r_state <= S_SWAP;
            r_cnt   <= '0;
          end else if (!run) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
            r_ena <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SWAP: begin
          for (int i = 0; i <= DELAYS; i++) r_b[i*N +: N] <= r_shadow[i];
          r_fcnt  <= FW'(DELAYS);
          r_frst  <= 1'b1;
          r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_done  <= 1'b1;
            r_state <= run ? S_RUN : S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - FW'(1);
            r_frst <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
